// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, a fixed-latency MUL path and a sticky TRAP.
// Outputs depend on the state and the class latched in DECODE; only ir_write and the store pc_write also follow their handshake input.
module multicycle_control_unit #(
    parameter int MUL_LATENCY = 4,
    parameter bit ENABLE_MUL  = 1'b1,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       instr_valid,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       branch,
    output logic       jump,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_2_reg,
    output logic       mul_en,
    output logic       mul_sel,
    output logic       reg_write,
    output logic       illegal
);

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;
    localparam logic [6:0] OP_JUMP   = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] F7_MUL    = 7'b0000001;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_MUL,
        S_TRAP
    } state_t;

    // C_NONE doubles as "unsupported" so the reset value of the class register is harmless.
    typedef enum logic [2:0] {
        C_NONE,
        C_ALU_R,
        C_ALU_I,
        C_BEQ,
        C_JUMP,
        C_LOAD,
        C_STORE,
        C_MUL
    } class_t;

    state_t           r_state;
    state_t           w_nextState;
    class_t           r_class;
    class_t           w_decClass;
    logic [CNT_W-1:0] r_mulCnt;
    logic             r_illegal;
    logic             w_mulDone;

    assign w_mulDone = (r_mulCnt == MUL_LAST);

    always_comb begin
        w_decClass = C_NONE;
        case (opcode)
            OP_ALU_R: begin
                if (funct7 == F7_MUL) begin
                    w_decClass = ENABLE_MUL ? C_MUL : C_NONE;
                end else begin
                    w_decClass = C_ALU_R;
                end
            end
            OP_ALU_I: w_decClass = C_ALU_I;
            OP_BEQ:   w_decClass = C_BEQ;
            OP_JUMP:  w_decClass = C_JUMP;
            OP_LOAD:  w_decClass = C_LOAD;
            OP_STORE: w_decClass = C_STORE;
            default:  w_decClass = C_NONE;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH: begin
                if (instr_valid) begin
                    w_nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_decClass)
                    C_MUL:   w_nextState = S_MUL;
                    C_NONE:  w_nextState = S_TRAP;
                    default: w_nextState = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (r_class == C_LOAD || r_class == C_STORE) begin
                    w_nextState = S_MEM;
                end else begin
                    w_nextState = S_FETCH;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_nextState = (r_class == C_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB: w_nextState = S_FETCH;
            S_MUL: begin
                if (w_mulDone) begin
                    w_nextState = S_FETCH;
                end
            end
            S_TRAP:  w_nextState = S_TRAP;
            default: w_nextState = S_FETCH;
        endcase
    end

    // The MUL counter idles at zero, so entering MUL from DECODE always starts a fresh count.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= S_FETCH;
            r_class   <= C_NONE;
            r_mulCnt  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_DECODE) begin
                r_class <= w_decClass;
            end
            if (r_state == S_MUL && !w_mulDone) begin
                r_mulCnt <= r_mulCnt + CNT_W'(1);
            end else begin
                r_mulCnt <= '0;
            end
            if (r_state == S_DECODE && w_nextState == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        alu_op    = ALU_ADD;
        alu_src   = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_2_reg = 1'b0;
        mul_en    = 1'b0;
        mul_sel   = 1'b0;
        reg_write = 1'b0;
        illegal   = r_illegal;
        case (r_state)
            S_FETCH: ir_write = instr_valid;
            S_EXEC: begin
                case (r_class)
                    C_ALU_R: begin
                        alu_op    = ALU_R;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    C_ALU_I: begin
                        alu_src   = 1'b1;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                    C_BEQ: begin
                        alu_op   = ALU_SUB;
                        branch   = 1'b1;
                        pc_write = 1'b1;
                    end
                    C_JUMP: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                    end
                    C_LOAD, C_STORE: alu_src = 1'b1;
                    default: ;
                endcase
            end
            // A store retires in its last MEM cycle; a load retires in WB.
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = (r_class == C_LOAD);
                mem_write = (r_class == C_STORE);
                pc_write  = (r_class == C_STORE) && mem_ready;
            end
            S_WB: begin
                mem_2_reg = 1'b1;
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            S_MUL: begin
                mul_en    = 1'b1;
                mul_sel   = w_mulDone;
                reg_write = w_mulDone;
                pc_write  = w_mulDone;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the stimulus pushes every expected non-zero control vector with its cycle number;
// a monitor pops one whenever a DUT drives a non-zero vector. DUT 0 has MUL enabled, DUT 1 does not.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

    localparam int LAT0 = 4;
    localparam int LAT1 = 2;

    localparam int C_R   = 0;
    localparam int C_I   = 1;
    localparam int C_B   = 2;
    localparam int C_J   = 3;
    localparam int C_LD  = 4;
    localparam int C_ST  = 5;
    localparam int C_MUL = 6;
    localparam int C_BAD = 7;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    typedef struct packed {
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] aluOp;
        logic       aluSrc;
        logic       branch;
        logic       jump;
        logic       memRead;
        logic       memWrite;
        logic       mem2Reg;
        logic       mulEn;
        logic       mulSel;
        logic       regWrite;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        int    cyc;
        ctrl_t v;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    logic       arstN[2];
    logic       instrValid[2];
    logic [6:0] opcode[2];
    logic [6:0] funct7[2];
    logic       memReady[2];

    logic       irW0, pcW0, src0, br0, jmp0, mrd0, mwr0, m2r0, men0, msel0, rw0, ill0;
    logic       irW1, pcW1, src1, br1, jmp1, mrd1, mwr1, m2r1, men1, msel1, rw1, ill1;
    logic [1:0] aop0, aop1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    multicycle_control_unit #(.MUL_LATENCY(LAT0), .ENABLE_MUL(1'b1), .CNT_W(3)) dut (
        .clk(clk), .arst_n(arstN[0]), .instr_valid(instrValid[0]), .opcode(opcode[0]),
        .funct7(funct7[0]), .mem_ready(memReady[0]), .ir_write(irW0), .pc_write(pcW0),
        .alu_op(aop0), .alu_src(src0), .branch(br0), .jump(jmp0), .mem_read(mrd0),
        .mem_write(mwr0), .mem_2_reg(m2r0), .mul_en(men0), .mul_sel(msel0),
        .reg_write(rw0), .illegal(ill0)
    );

    multicycle_control_unit #(.MUL_LATENCY(LAT1), .ENABLE_MUL(1'b0), .CNT_W(1)) dutNoMul (
        .clk(clk), .arst_n(arstN[1]), .instr_valid(instrValid[1]), .opcode(opcode[1]),
        .funct7(funct7[1]), .mem_ready(memReady[1]), .ir_write(irW1), .pc_write(pcW1),
        .alu_op(aop1), .alu_src(src1), .branch(br1), .jump(jmp1), .mem_read(mrd1),
        .mem_write(mwr1), .mem_2_reg(m2r1), .mul_en(men1), .mul_sel(msel1),
        .reg_write(rw1), .illegal(ill1)
    );

    function automatic ctrl_t packCtrl(input int d);
        if (d == 0) return {irW0, pcW0, aop0, src0, br0, jmp0, mrd0, mwr0, m2r0, men0, msel0, rw0, ill0};
        return {irW1, pcW1, aop1, src1, br1, jmp1, mrd1, mwr1, m2r1, men1, msel1, rw1, ill1};
    endfunction

    // Reference model: instruction class from the opcode table, then the control vector for cycle k of that instruction.
    function automatic int classify(input int d, input logic [6:0] op, input logic [6:0] f7);
        case (op)
            OP_R:    return (f7 == 7'b0000001) ? ((d == 0) ? C_MUL : C_BAD) : C_R;
            OP_I:    return C_I;
            OP_B:    return C_B;
            OP_J:    return C_J;
            OP_LD:   return C_LD;
            OP_ST:   return C_ST;
            default: return C_BAD;
        endcase
    endfunction

    function automatic ctrl_t expectedCtrl(input int cls, input int k, input int waits, input int lat);
        ctrl_t e;
        e = '0;
        if (k == 0) begin
            e.irWrite = 1'b1;
        end else if (k >= 2) begin
            case (cls)
                C_R:  begin e.aluOp = 2'b10; e.regWrite = 1'b1; e.pcWrite = 1'b1; end
                C_I:  begin e.aluSrc = 1'b1; e.regWrite = 1'b1; e.pcWrite = 1'b1; end
                C_B:  begin e.aluOp = 2'b01; e.branch = 1'b1; e.pcWrite = 1'b1; end
                C_J:  begin e.jump = 1'b1; e.pcWrite = 1'b1; end
                C_ST: begin
                    e.aluSrc = 1'b1;
                    e.memWrite = (k >= 3);
                    e.pcWrite = (k == 3 + waits);
                end
                C_LD: begin
                    if (k <= 3 + waits) begin
                        e.aluSrc = 1'b1;
                        e.memRead = (k >= 3);
                    end else begin
                        e.mem2Reg = 1'b1; e.regWrite = 1'b1; e.pcWrite = 1'b1;
                    end
                end
                C_MUL: begin
                    e.mulEn = 1'b1;
                    if (k == 1 + lat) begin
                        e.mulSel = 1'b1; e.regWrite = 1'b1; e.pcWrite = 1'b1;
                    end
                end
                default: e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic monitorStep(input int d);
        ctrl_t a;
        exp_t  e;
        bit    have;
        a = packCtrl(d);
        have = 1'b0;
        if (a != '0) begin
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            checks++;
            if (!have) begin
                errors++;
                $display("[TB] FAIL unexpected_ctrl dut%0d: got %b at cycle %0d, expected nothing", d, a, cyc);
            end else if (e.v !== a || e.cyc != cyc) begin
                errors++;
                $display("[TB] FAIL ctrl dut%0d: got %b at cycle %0d, expected %b at cycle %0d", d, a, cyc, e.v, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        monitorStep(0);
        monitorStep(1);
    end

    task automatic applyReset(input int d);
        arstN[d] = 1'b0;
        instrValid[d] = 1'b0;
        memReady[d] = 1'b0;
        #1;
        checkOutput($sformatf("async_reset_outputs_dut%0d", d), 32'(packCtrl(d)), 32'd0);
        @(posedge clk); #1;
        arstN[d] = 1'b1;
        #1;
        checkOutput($sformatf("post_reset_idle_dut%0d", d), 32'(packCtrl(d)), 32'd0);
    endtask

    // Issues one instruction starting in FETCH. waits = mem_ready-low cycles (or TRAP cycles to observe);
    // abortAt >= 0 pulses arst_n in that cycle of the instruction. Must be called at posedge+1 with the DUT in FETCH.
    task automatic applyStimulus(input int d, input logic [6:0] op, input logic [6:0] f7,
                                 input int waits, input int abortAt);
        int    cls, len, stop, lat, c0;
        ctrl_t e;
        lat = (d == 0) ? LAT0 : LAT1;
        cls = classify(d, op, f7);
        case (cls)
            C_LD:    len = 5 + waits;
            C_ST:    len = 4 + waits;
            C_MUL:   len = 2 + lat;
            C_BAD:   len = 2 + waits;
            default: len = 3;
        endcase
        stop = (cls == C_BAD) ? len : abortAt;
        c0 = cyc;
        for (int k = 0; k < len; k++) begin
            if (stop < 0 || k < stop) begin
                e = expectedCtrl(cls, k, waits, lat);
                if (e != '0) begin
                    if (d == 0) q0.push_back('{c0 + k, e});
                    else        q1.push_back('{c0 + k, e});
                end
            end
        end
        for (int k = 0; k <= len; k++) begin
            if (k == stop) begin
                applyReset(d);
                break;
            end
            if (k == len) break;
            instrValid[d] = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            opcode[d] = op;
            funct7[d] = f7;
            if ((cls == C_LD || cls == C_ST) && k >= 3 && k <= 3 + waits) begin
                memReady[d] = (k == 3 + waits);
            end else begin
                memReady[d] = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        instrValid[d] = 1'b0;
        memReady[d] = 1'b0;
    endtask

    task automatic randomInstr(input int d);
        int         pick;
        logic [6:0] f7;
        f7 = 7'($urandom);
        pick = $urandom_range(0, (d == 0) ? 6 : 5);
        case (pick)
            0: applyStimulus(d, OP_R, $urandom_range(0, 1) ? 7'b0100000 : 7'b0000000, 0, -1);
            1: applyStimulus(d, OP_I, f7, 0, -1);
            2: applyStimulus(d, OP_B, f7, 0, -1);
            3: applyStimulus(d, OP_J, f7, 0, -1);
            4: applyStimulus(d, OP_LD, f7, $urandom_range(0, 3), -1);
            5: applyStimulus(d, OP_ST, f7, $urandom_range(0, 3), -1);
            default: applyStimulus(d, OP_R, 7'b0000001, 0, -1);
        endcase
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            arstN[d] = 1'b0;
            instrValid[d] = 1'b0;
            opcode[d] = 7'd0;
            funct7[d] = 7'd0;
            memReady[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs_dut0", 32'(packCtrl(0)), 32'd0);
        checkOutput("reset_outputs_dut1", 32'(packCtrl(1)), 32'd0);
        arstN[0] = 1'b1;
        arstN[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idle_ir_write", 32'(irW0), 32'd0);
        end
        @(posedge clk); #1;

        // Directed: addi, lw with two wait states, mul, beq+jal back-to-back, zero-wait store and load.
        applyStimulus(0, OP_I, 7'd0, 0, -1);
        applyStimulus(0, OP_LD, 7'd0, 2, -1);
        applyStimulus(0, OP_R, 7'b0000001, 0, -1);
        applyStimulus(0, OP_B, 7'd0, 0, -1);
        applyStimulus(0, OP_J, 7'd0, 0, -1);
        applyStimulus(0, OP_ST, 7'd0, 0, -1);
        applyStimulus(0, OP_LD, 7'd0, 0, -1);

        for (int i = 0; i < 150; i++) begin
            randomInstr(0);
        end

        // Reset mid-MUL and mid-MEM wait, then confirm a clean restart each time.
        applyStimulus(0, OP_R, 7'b0000001, 0, 4);
        applyStimulus(0, OP_I, 7'd0, 0, -1);
        applyStimulus(0, OP_LD, 7'd0, 3, 5);
        applyStimulus(0, OP_ST, 7'd0, 1, -1);

        // Unknown opcode traps; illegal must hold until reset clears it.
        applyStimulus(0, 7'b1111111, 7'd0, 20, -1);
        applyStimulus(0, OP_I, 7'd0, 0, -1);

        for (int i = 0; i < 20; i++) begin
            randomInstr(1);
        end
        applyStimulus(1, OP_R, 7'b0000000, 0, -1);
        applyStimulus(1, OP_R, 7'b0000001, 6, -1);
        applyStimulus(1, OP_J, 7'd0, 0, -1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained_dut0", 32'(q0.size()), 32'd0);
        checkOutput("scoreboard_drained_dut1", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
